// File: rtl/spi_slave.sv
// SPI mode-0 responder with a 4-register CPU port. SPI pins are oversampled in the clk domain.
// Optional: define SPI_SLAVE_IRQ_EN to add the interrupt-enable register (addr 3) and a live irq.
module spi_slave #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_RESET  = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       rnw,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       sclk,
   input  logic       ss,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       irq
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sclkSync_q, ssSync_q, mosiSync_q;
   logic                   sclkHist_q, ssHist_q;
   logic                   sclkS, ssS, mosiS;
   logic                   sclkRise, sclkFall, ssFall, ssRise;

   state_t     state_q, state_d;
   logic [7:0] shiftTx_q, shiftTx_d;
   logic [6:0] shiftRx_q, shiftRx_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic       pending_q, pending_d;
   logic       miso_q, miso_d;
   logic       misoOe_q, misoOe_d;
   logic [7:0] hold_q, hold_d;
   logic       txFull_q, txFull_d;
   logic [7:0] fill_q, fill_d;
   logic [7:0] rxData_q, rxData_d;
   logic       rxFull_q, rxFull_d;
   logic       overrun_q, overrun_d;
   logic [7:0] dout_q, dout_d;

   logic       rdRx, wrTx, wrStat, wrFill, wrIe;
   logic       loadTx, byteDone;
   logic [7:0] loadVal, statusByte, ieByte;

   // Pin synchronisers plus one history flop; ss idles high, sclk idles low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclkSync_q <= '0;
         ssSync_q   <= '1;
         mosiSync_q <= '0;
         sclkHist_q <= 1'b0;
         ssHist_q   <= 1'b1;
      end else begin
         sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
         ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], ss};
         mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
         sclkHist_q <= sclkSync_q[SYNC_STAGES-1];
         ssHist_q   <= ssSync_q[SYNC_STAGES-1];
      end
   end

   assign sclkS    = sclkSync_q[SYNC_STAGES-1];
   assign ssS      = ssSync_q[SYNC_STAGES-1];
   assign mosiS    = mosiSync_q[SYNC_STAGES-1];
   assign sclkRise = sclkS & ~sclkHist_q;
   assign sclkFall = ~sclkS & sclkHist_q;
   assign ssFall   = ~ssS & ssHist_q;
   assign ssRise   = ssS & ~ssHist_q;

   assign rdRx   = enable & rnw & (addr == 2'd0);
   assign wrTx   = enable & ~rnw & (addr == 2'd0);
   assign wrStat = enable & ~rnw & (addr == 2'd1);
   assign wrFill = enable & ~rnw & (addr == 2'd2);
   assign wrIe   = enable & ~rnw & (addr == 2'd3);

   assign loadVal    = txFull_q ? hold_q : fill_q;
   assign statusByte = {3'b000, (bitcnt_q != 3'd0), (state_q == ACTIVE), overrun_q, txFull_q, rxFull_q};

`ifdef SPI_SLAVE_IRQ_EN
   logic [1:0] ie_q, ie_d;
   logic       irq_q, irq_d;

   assign ieByte = {6'b000000, ie_q};
   assign irq    = irq_q;

   always_comb begin
      ie_d  = ie_q;
      irq_d = (rxFull_q & ie_q[0]) | (overrun_q & ie_q[1]);
      if (wrIe) ie_d = din[1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie_q  <= 2'b00;
         irq_q <= 1'b0;
      end else begin
         ie_q  <= ie_d;
         irq_q <= irq_d;
      end
   end
`else
   logic unusedIe;

   assign ieByte   = 8'h00;
   assign irq      = 1'b0;
   assign unusedIe = wrIe;
`endif

   // Frame FSM and CPU register updates; SPI and CPU actions in the same cycle both take effect.
   always_comb begin
      state_d   = state_q;
      shiftTx_d = shiftTx_q;
      shiftRx_d = shiftRx_q;
      bitcnt_d  = bitcnt_q;
      pending_d = pending_q;
      miso_d    = miso_q;
      misoOe_d  = misoOe_q;
      hold_d    = hold_q;
      txFull_d  = txFull_q;
      fill_d    = fill_q;
      rxData_d  = rxData_q;
      rxFull_d  = rxFull_q;
      overrun_d = overrun_q;
      dout_d    = dout_q;
      loadTx    = 1'b0;
      byteDone  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ssFall) begin
               shiftTx_d = loadVal;
               miso_d    = loadVal[7];
               misoOe_d  = 1'b1;
               bitcnt_d  = 3'd0;
               pending_d = 1'b0;
               loadTx    = 1'b1;
               state_d   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (ssRise) begin
               state_d   = IDLE;
               bitcnt_d  = 3'd0;
               pending_d = 1'b0;
               miso_d    = 1'b1;
               misoOe_d  = 1'b0;
            end else if (sclkRise) begin
               shiftRx_d = {shiftRx_q[5:0], mosiS};
               if (bitcnt_q == 3'd7) begin
                  byteDone  = 1'b1;
                  bitcnt_d  = 3'd0;
                  pending_d = 1'b1;
               end else begin
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end else if (sclkFall && (bitcnt_q != 3'd0 || pending_q)) begin
               // A fall with no rise yet in this frame is ignored by the guard above.
               if (pending_q) begin
                  shiftTx_d = loadVal;
                  miso_d    = loadVal[7];
                  pending_d = 1'b0;
                  loadTx    = 1'b1;
               end else begin
                  shiftTx_d = {shiftTx_q[6:0], shiftTx_q[7]};
                  miso_d    = shiftTx_q[6];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (loadTx) txFull_d = 1'b0;
      if (wrTx) begin
         hold_d   = din;
         txFull_d = 1'b1;
      end
      if (wrFill) fill_d = din;
      if (rdRx) rxFull_d = 1'b0;
      if (wrStat && din[2]) overrun_d = 1'b0;

      if (byteDone) begin
         rxData_d = {shiftRx_q, mosiS};
         rxFull_d = 1'b1;
         if (rxFull_q && !rdRx) overrun_d = 1'b1;
      end

      if (enable && rnw) begin
         unique case (addr)
            2'd0:    dout_d = rxData_q;
            2'd1:    dout_d = statusByte;
            2'd2:    dout_d = fill_q;
            default: dout_d = ieByte;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shiftTx_q <= 8'h00;
         shiftRx_q <= 7'h00;
         bitcnt_q  <= 3'd0;
         pending_q <= 1'b0;
         miso_q    <= 1'b1;
         misoOe_q  <= 1'b0;
         hold_q    <= 8'h00;
         txFull_q  <= 1'b0;
         fill_q    <= FILL_RESET;
         rxData_q  <= 8'h00;
         rxFull_q  <= 1'b0;
         overrun_q <= 1'b0;
         dout_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         shiftTx_q <= shiftTx_d;
         shiftRx_q <= shiftRx_d;
         bitcnt_q  <= bitcnt_d;
         pending_q <= pending_d;
         miso_q    <= miso_d;
         misoOe_q  <= misoOe_d;
         hold_q    <= hold_d;
         txFull_q  <= txFull_d;
         fill_q    <= fill_d;
         rxData_q  <= rxData_d;
         rxFull_q  <= rxFull_d;
         overrun_q <= overrun_d;
         dout_q    <= dout_d;
      end
   end

   assign dout    = dout_q;
   assign miso    = miso_q;
   assign miso_oe = misoOe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master with scoreboards for the bytes
// the master should receive on miso and the bytes the CPU should read back from RX.
module tb_spi_slave;

   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       rnw;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       sclk;
   logic       ss;
   logic       mosi;
   logic       miso;
   logic       misoOe;
   logic       irq;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] txQ[$];
   logic [7:0] rxQ[$];
   bit         modelRxFull = 1'b0;
   logic [7:0] rdData;

   always #5 clk = ~clk;

   spi_slave #(
      .SYNC_STAGES(SYNC),
      .FILL_RESET (8'hFF)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .rnw    (rnw),
      .addr   (addr),
      .din    (din),
      .dout   (dout),
      .sclk   (sclk),
      .ss     (ss),
      .mosi   (mosi),
      .miso   (miso),
      .miso_oe(misoOe),
      .irq    (irq)
   );

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %02h expected %02h", tag, actual, expected);
      end
   endtask

   task automatic cpuWrite(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      enable = 1'b1; rnw = 1'b0; addr = a; din = d;
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic cpuRead(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      enable = 1'b1; rnw = 1'b1; addr = a;
      @(negedge clk);
      enable = 1'b0;
      d = dout;
   endtask

   // Reads RX and compares against the oldest byte the model says is still held.
   task automatic readRx(input string tag);
      logic [7:0] d;
      logic [7:0] exp;
      cpuRead(2'd0, d);
      exp = 8'hxx;
      if (rxQ.size() != 0) exp = rxQ.pop_front();
      checkOutput(tag, d, exp);
      modelRxFull = 1'b0;
   endtask

   task automatic ssLow();
      ss = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      checkOutput("oe_on", {7'b0, misoOe}, 8'h01);
      repeat (HALF - SYNC - 1) @(negedge clk);
   endtask

   task automatic ssHigh();
      ss = 1'b1;
      repeat (SYNC + 1) @(negedge clk);
      checkOutput("oe_off", {7'b0, misoOe}, 8'h00);
      checkOutput("miso_idle", {7'b0, miso}, 8'h01);
      repeat (4) @(negedge clk);
   endtask

   // Clocks nbits of txByte out on mosi; full bytes feed the scoreboards. With readAtDone the
   // CPU reads RX in exactly the cycle the 8th rising edge completes the byte inside the DUT.
   task automatic applyStimulus(input logic [7:0] txByte, input int nbits, input bit readAtDone);
      logic [7:0] got;
      logic [7:0] exp;
      logic [7:0] d;
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = txByte[7-i];
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         got  = {got[6:0], miso};
         if (readAtDone && i == 7) begin
            repeat (SYNC) @(negedge clk);
            enable = 1'b1; rnw = 1'b1; addr = 2'd0;
            @(negedge clk);
            enable = 1'b0;
            d   = dout;
            exp = 8'hxx;
            if (rxQ.size() != 0) exp = rxQ.pop_front();
            checkOutput("rd_at_done", d, exp);
            modelRxFull = 1'b0;
            repeat (HALF - SYNC - 1) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         sclk = 1'b0;
      end
      if (nbits == 8) begin
         exp = 8'hxx;
         if (txQ.size() != 0) exp = txQ.pop_front();
         checkOutput("miso_byte", got, exp);
         if (modelRxFull && rxQ.size() != 0) void'(rxQ.pop_front());
         rxQ.push_back(txByte);
         modelRxFull = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; rnw = 1'b1; addr = 2'd0; din = 8'h00;
      sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_miso", {7'b0, miso}, 8'h01);
      checkOutput("rst_oe", {7'b0, misoOe}, 8'h00);
      checkOutput("rst_irq", {7'b0, irq}, 8'h00);
      checkOutput("rst_dout", dout, 8'h00);
      reset = 1'b0;
      cpuRead(2'd1, rdData); checkOutput("rst_status", rdData, 8'h00);
      cpuRead(2'd2, rdData); checkOutput("rst_fill", rdData, 8'hFF);
      cpuRead(2'd3, rdData); checkOutput("rst_ie", rdData, 8'h00);

      $display("[TB] single byte with TX hold");
      cpuWrite(2'd0, 8'hA5); txQ.push_back(8'hA5);
      cpuRead(2'd1, rdData); checkOutput("status_txfull", rdData, 8'h02);
      ssLow();
      applyStimulus(8'h3C, 8, 1'b0);
      ssHigh();
      cpuRead(2'd1, rdData); checkOutput("status_rxfull", rdData, 8'h01);
      readRx("rx_3c");
      cpuRead(2'd1, rdData); checkOutput("status_empty", rdData, 8'h00);

      $display("[TB] back-to-back bytes from fill, overrun");
      cpuWrite(2'd2, 8'h00);
      txQ.push_back(8'h00); txQ.push_back(8'h00);
      ssLow();
      applyStimulus(8'h11, 8, 1'b0);
      applyStimulus(8'h22, 8, 1'b0);
      ssHigh();
      cpuRead(2'd1, rdData); checkOutput("status_overrun", rdData, 8'h05);
      cpuWrite(2'd1, 8'h04);
      cpuRead(2'd1, rdData); checkOutput("status_ovr_clr", rdData, 8'h01);
      readRx("rx_22");

      $display("[TB] aborted frame then full frame");
      ssLow();
      applyStimulus(8'hF0, 5, 1'b0);
      ssHigh();
      cpuRead(2'd1, rdData); checkOutput("status_abort", rdData, 8'h00);
      cpuWrite(2'd0, 8'h5A); txQ.push_back(8'h5A);
      ssLow();
      applyStimulus(8'hC3, 8, 1'b0);
      ssHigh();
      readRx("rx_c3");

      $display("[TB] RX read in completion cycle");
      txQ.push_back(8'h00); txQ.push_back(8'h00);
      ssLow();
      applyStimulus(8'h96, 8, 1'b0);
      applyStimulus(8'h69, 8, 1'b1);
      ssHigh();
      cpuRead(2'd1, rdData); checkOutput("status_no_ovr", rdData, 8'h01);
      readRx("rx_69");

`ifdef SPI_SLAVE_IRQ_EN
      $display("[TB] irq on rx");
      cpuWrite(2'd3, 8'h01);
      cpuRead(2'd3, rdData); checkOutput("ie_read", rdData, 8'h01);
      checkOutput("irq_idle", {7'b0, irq}, 8'h00);
      txQ.push_back(8'h00);
      ssLow();
      applyStimulus(8'hE7, 8, 1'b0);
      ssHigh();
      checkOutput("irq_set", {7'b0, irq}, 8'h01);
      readRx("rx_e7");
      checkOutput("irq_lag", {7'b0, irq}, 8'h01);
      @(negedge clk);
      checkOutput("irq_clr", {7'b0, irq}, 8'h00);
`else
      $display("[TB] irq disabled build");
      cpuWrite(2'd3, 8'h03);
      cpuRead(2'd3, rdData); checkOutput("ie_read", rdData, 8'h00);
      txQ.push_back(8'h00);
      ssLow();
      applyStimulus(8'hE7, 8, 1'b0);
      ssHigh();
      checkOutput("irq_off", {7'b0, irq}, 8'h00);
      readRx("rx_e7");
      checkOutput("irq_off2", {7'b0, irq}, 8'h00);
`endif

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
